// File: rtl/control_unit_pkg.sv
// control_unit_pkg: opcodes, FSM states, RF write-source codes and instruction classes shared by control and datapath.
package control_unit_pkg;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [1:0] RF_MEM   = 2'b00;
  localparam logic [1:0] RF_ALU   = 2'b01;
  localparam logic [1:0] RF_PC4   = 2'b10;
  localparam logic [1:0] RF_PCIMM = 2'b11;
  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEMORY    = 3'd3,
    WRITEBACK = 3'd4,
    TRAP      = 3'd5
  } state_t;
  typedef struct packed {
    logic alu_r;
    logic alu_i;
    logic auipc;
    logic jal;
    logic jalr;
    logic branch;
    logic load;
    logic store;
    logic illegal;
  } iclass_t;
endpackage

// File: rtl/control_decoder.sv
// control_decoder: maps a 7-bit opcode to a one-hot instruction class.
module control_decoder
  import control_unit_pkg::*;
(
  input  logic [6:0] opcode,
  output iclass_t    cls
);
  always_comb begin
    cls = '0;
    cls.alu_r   = opcode == OPC_OP || opcode == OPC_OP_32;
    cls.alu_i   = opcode == OPC_OP_IMM || opcode == OPC_OP_IMM_32 || opcode == OPC_LUI;
    cls.auipc   = opcode == OPC_AUIPC;
    cls.jal     = opcode == OPC_JAL;
    cls.jalr    = opcode == OPC_JALR;
    cls.branch  = opcode == OPC_BRANCH;
    cls.load    = opcode == OPC_LOAD;
    cls.store   = opcode == OPC_STORE;
    cls.illegal = !(cls.alu_r || cls.alu_i || cls.auipc || cls.jal || cls.jalr ||
                    cls.branch || cls.load || cls.store);
  end
endmodule

// File: rtl/control_unit.sv
// control_unit: multi-cycle FSM sequencing fetch/decode/execute/memory/writeback plus retired-instruction counter.
// Define CONTROL_UNIT_TRAP_EN to trap unsupported opcodes; otherwise they retire as NOPs.
module control_unit
  import control_unit_pkg::*;
#(
  parameter int INSTRET_W = 64
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic [6:0]           opcode,
  output logic                 load_ir,
  output logic                 load_pc,
  output logic                 pc_next_sel,
  output logic                 pc_adder_sel,
  output logic                 WE_RF,
  output logic                 WE_MEM,
  output logic [1:0]           RF_din_sel,
  output logic                 ULA_din2_sel,
  output logic [2:0]           state,
  output logic [INSTRET_W-1:0] instret,
  output logic                 illegal
);
  state_t  st, nx;
  iclass_t cls;
  control_decoder u_dec (.opcode(opcode), .cls(cls));
  assign state = st;
  always_ff @(posedge CLK or posedge reset)
    if (reset) begin
      st      <= FETCH;
      instret <= '0;
    end else begin
      st <= nx;
      if (load_pc) instret <= instret + INSTRET_W'(1);
    end
  always_comb begin
    nx           = FETCH;
    load_ir      = 1'b0;
    load_pc      = 1'b0;
    pc_next_sel  = 1'b0;
    pc_adder_sel = 1'b0;
    WE_RF        = 1'b0;
    WE_MEM       = 1'b0;
    RF_din_sel   = RF_MEM;
    ULA_din2_sel = 1'b0;
    illegal      = 1'b0;
    unique case (st)
      FETCH: begin
        load_ir = 1'b1;
        nx      = DECODE;
      end
      DECODE: nx = EXECUTE;
      EXECUTE: begin
        WE_RF        = cls.alu_r || cls.alu_i || cls.auipc || cls.jal || cls.jalr;
        load_pc      = !(cls.load || cls.store);
        pc_next_sel  = cls.jal || cls.jalr || cls.branch;
        pc_adder_sel = cls.jalr;
        ULA_din2_sel = cls.alu_i || cls.load || cls.store;
        RF_din_sel   = cls.auipc ? RF_PCIMM : (cls.jal || cls.jalr) ? RF_PC4 :
                       (cls.alu_r || cls.alu_i) ? RF_ALU : RF_MEM;
        illegal      = cls.illegal;
        nx           = (cls.load || cls.store) ? MEMORY : FETCH;
`ifdef CONTROL_UNIT_TRAP_EN
        if (cls.illegal) begin
          load_pc = 1'b0;
          nx      = TRAP;
        end
`endif
      end
      MEMORY: begin
        ULA_din2_sel = 1'b1;
        WE_MEM       = cls.store;
        load_pc      = cls.store;
        nx           = cls.store ? FETCH : WRITEBACK;
      end
      WRITEBACK: begin
        ULA_din2_sel = 1'b1;
        WE_RF        = 1'b1;
        load_pc      = 1'b1;
        RF_din_sel   = RF_MEM;
      end
      TRAP: begin
        illegal = 1'b1;
`ifdef CONTROL_UNIT_TRAP_EN
        nx      = TRAP;
`endif
      end
      default: nx = FETCH;
    endcase
  end
endmodule
